noise_table_loader: RTL and testbench
=====================================

Name: noise_table_loader

Overview:
- Writer for the blue-noise threshold RAM that the dithering stage reads.
- Accepts a byte stream (valid/ready) carrying a 2^ABITS-entry noise table followed by a 16-bit additive checksum.
- Broadcasts each accepted byte to the write ports of both noise RAM banks, then verifies the checksum.
- Raises table_valid only after a verified load; downstream dithering uses the RAM contents only while table_valid is 1.

Parameters:
- ABITS, 12, noise RAM address width; a table is exactly 2^ABITS bytes.
- DBITS, 8, noise entry width; fixed at 8; the stream is byte-wide.

Ports:
- clk  input  1  sole clock; all logic rising-edge.
- rstn  input  1  reset, asynchronous, active-low; deassertion synchronised externally.
- start  input  1  single-cycle request to begin a load.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader can accept a byte.
- bram_we  output  1  write strobe, common to both RAM banks.
- bram_addr  output  ABITS  write address.
- bram_din  output  8  write data.
- busy  output  1  high in LOAD, CSUM_LO, CSUM_HI and CHECK.
- done  output  1  one-cycle pulse when a load finishes, pass or fail.
- table_valid  output  1  RAM holds a verified table.
- csum_err  output  1  last load failed the checksum; sticky until the next start.

Behaviour:
- Reset (rstn=0, asynchronous) sets:
  - state=IDLE, byte counter=0, sum=0, expected=0.
  - Outputs: s_ready=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0, table_valid=0, csum_err=0.
- Reset mid-load: the RAM contents are undefined and table_valid stays 0 until a later load verifies.
- Handshake: a transfer occurs on any cycle with s_valid & s_ready.
  - s_ready is decoded from registered state: 1 in LOAD, CSUM_LO and CSUM_HI; 0 otherwise.
  - s_data is sampled only on a transfer. s_valid may drop at any time without penalty.
- States:
  - IDLE: wait for start.
  - LOAD: take table bytes.
  - CSUM_LO: take expected[7:0].
  - CSUM_HI: take expected[15:8].
  - CHECK: compare for one cycle.
  - FINISH: terminal until the next start.
- Transitions:
  - IDLE or FINISH, start=1 → LOAD. Same edge clears counter, sum, table_valid and csum_err.
  - LOAD, transfer with counter = 2^ABITS-1 → CSUM_LO. Otherwise counter increments.
  - CSUM_LO, transfer → CSUM_HI.
  - CSUM_HI, transfer → CHECK.
  - CHECK → FINISH, with done=1 for that one cycle.
    - If sum == expected: table_valid=1, csum_err=0.
    - Otherwise: table_valid=0, csum_err=1.
  - start while busy is ignored.
- Abort:
  - abort=1 in any state → IDLE next edge; it takes priority over start and over a transfer on the same cycle.
  - Effects: table_valid=0, csum_err unchanged, done not pulsed, any write in flight for that cycle suppressed.
- Writes (LOAD transfers only), registered with 1-cycle latency. On the cycle after a transfer:
  - bram_we=1, bram_addr=counter value at transfer, bram_din=s_data.
  - bram_we=0 on all other cycles; addr and din hold their last values.
  - Checksum bytes are never written.
- Checksum arithmetic:
  - sum is 16 bits: sum <= sum + {8'd0, s_data} on each LOAD transfer, modulo 2^16; carries are discarded.
  - expected = {hi byte, lo byte}.
- Addresses are strictly sequential 0 .. 2^ABITS-1 with no wrap. Exactly 2^ABITS writes occur per completed load.
- Back-to-back transfers sustain one byte per clock.

Test Plan:
- Full load, data byte = addr[7:0], s_valid held high, trailer bytes 0x00 then 0xF8:
  - 4096 writes, addr 0..4095 contiguous, each write 1 cycle after its transfer.
  - done pulses once; table_valid=1, csum_err=0.
- Same data with s_valid randomly deasserted ~50% → identical write sequence (ignoring gaps) and final flags identical.
- Same data with trailer 0x01, 0xF8 → done pulses; table_valid=0, csum_err=1.
- Second, passing load started from FINISH with table_valid=1:
  - table_valid=0 the cycle after start.
  - table_valid=1 after CHECK; csum_err cleared.
- Mid-load interruptions, each starting from a load at address 100:
  - Assert start → ignored.
  - Assert abort at address 200 → IDLE next cycle, no write for that byte, done=0, table_valid=0.
  - Separate run: rstn low at address 100 → all outputs at reset values immediately, without waiting for a clock edge.
- Abort and s_valid together in CSUM_HI → no CHECK state, done never pulses, s_ready=0 the following cycle.

Source files
------------

// File: rtl/noise_table_loader.sv
// Streams a 2^ABITS-byte blue-noise table into both noise RAM banks and
// validates it against the 16-bit additive checksum that trails the table.
module noise_table_loader #(
    parameter int ABITS = 12,
    parameter int DBITS = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [DBITS-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             bram_we,
    output logic [ABITS-1:0] bram_addr,
    output logic [DBITS-1:0] bram_din,
    output logic             busy,
    output logic             done,
    output logic             table_valid,
    output logic             csum_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CSUM_LO = 3'd2,
        CSUM_HI = 3'd3,
        CHECK   = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic [ABITS-1:0] LAST_ADDR = {ABITS{1'b1}};

    // Modulo-2^16 accumulation; carries out of bit 15 are dropped.
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [DBITS-1:0] b);
        return acc + {{(16-DBITS){1'b0}}, b};
    endfunction

    state_t             state_r, next_state_s;
    logic [ABITS-1:0]   cnt_r;
    logic [15:0]        sum_r;
    logic [15:0]        exp_r;
    logic               s_ready_r, busy_r, next_ready_s, next_busy_s;
    logic               bram_we_r, done_r, table_valid_r, csum_err_r;
    logic [ABITS-1:0]   bram_addr_r;
    logic [DBITS-1:0]   bram_din_r;
    logic               xfer_s;

    assign xfer_s = s_valid & s_ready_r;

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, FINISH: begin
                if (start) next_state_s = LOAD;
                else       next_state_s = state_r;
            end
            LOAD: begin
                if (xfer_s && (cnt_r == LAST_ADDR)) next_state_s = CSUM_LO;
                else                                next_state_s = LOAD;
            end
            CSUM_LO: begin
                if (xfer_s) next_state_s = CSUM_HI;
                else        next_state_s = CSUM_LO;
            end
            CSUM_HI: begin
                if (xfer_s) next_state_s = CHECK;
                else        next_state_s = CSUM_HI;
            end
            CHECK:   next_state_s = FINISH;
            default: next_state_s = IDLE;
        endcase
        if (abort) next_state_s = IDLE;
        else       next_state_s = next_state_s;
    end

    // Ready/busy are registered copies of the decode of the next state.
    always_comb begin
        next_ready_s = 1'b0;
        next_busy_s  = 1'b0;
        case (next_state_s)
            LOAD, CSUM_LO, CSUM_HI: begin
                next_ready_s = 1'b1;
                next_busy_s  = 1'b1;
            end
            CHECK:   next_busy_s = 1'b1;
            default: begin
                next_ready_s = 1'b0;
                next_busy_s  = 1'b0;
            end
        endcase
    end

    // State register with its decoded handshake/busy flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            s_ready_r <= next_ready_s;
            busy_r    <= next_busy_s;
        end
    end

    // Datapath: counter, checksum, RAM write port and result flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r         <= {ABITS{1'b0}};
            sum_r         <= 16'd0;
            exp_r         <= 16'd0;
            bram_we_r     <= 1'b0;
            bram_addr_r   <= {ABITS{1'b0}};
            bram_din_r    <= {DBITS{1'b0}};
            done_r        <= 1'b0;
            table_valid_r <= 1'b0;
            csum_err_r    <= 1'b0;
        end else begin
            bram_we_r <= 1'b0;
            done_r    <= 1'b0;
            if (abort) begin
                table_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE, FINISH: begin
                        if (start) begin
                            cnt_r         <= {ABITS{1'b0}};
                            sum_r         <= 16'd0;
                            table_valid_r <= 1'b0;
                            csum_err_r    <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (xfer_s) begin
                            bram_we_r   <= 1'b1;
                            bram_addr_r <= cnt_r;
                            bram_din_r  <= s_data;
                            cnt_r       <= cnt_r + ABITS'(1);
                            sum_r       <= csum_add(sum_r, s_data);
                        end
                    end
                    CSUM_LO: if (xfer_s) exp_r[7:0]  <= s_data;
                    CSUM_HI: if (xfer_s) exp_r[15:8] <= s_data;
                    CHECK: begin
                        done_r        <= 1'b1;
                        table_valid_r <= (sum_r == exp_r);
                        csum_err_r    <= (sum_r != exp_r);
                    end
                    default: done_r <= 1'b0;
                endcase
            end
        end
    end

    assign s_ready     = s_ready_r;
    assign busy        = busy_r;
    assign bram_we     = bram_we_r;
    assign bram_addr   = bram_addr_r;
    assign bram_din    = bram_din_r;
    assign done        = done_r;
    assign table_valid = table_valid_r;
    assign csum_err    = csum_err_r;

endmodule

// File: tb/tb_noise_table_loader.sv
// Directed bench for noise_table_loader: table-driven full loads plus
// hand-written abort, ignored-start and asynchronous-reset sequences.
module tb_noise_table_loader;

    localparam int ABITS = 12;
    localparam int TBL   = 1 << ABITS;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start, abort, s_valid;
    logic [7:0]       s_data;
    logic             s_ready, bram_we, busy, done, table_valid, csum_err;
    logic [ABITS-1:0] bram_addr;
    logic [7:0]       bram_din;

    noise_table_loader #(.ABITS(ABITS), .DBITS(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .busy(busy), .done(done), .table_valid(table_valid), .csum_err(csum_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        int         gap_pct;
        logic       exp_tv;
        logic       exp_err;
    } vec_t;

    vec_t vecs[4];
    int total = 0;
    int bad   = 0;
    int idx, writes, wr_err, dones;
    logic [7:0] cur_lo, cur_hi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        logic [31:0] iv;
        iv = i;
        if (i < TBL)       return iv[7:0];
        else if (i == TBL) return cur_lo;
        else               return cur_hi;
    endfunction

    // One clock: drive at a falling edge, predict the registered write, check next falling edge.
    task automatic cyc(input logic v, input logic st, input logic ab);
        logic        xf, exp_we;
        logic [31:0] ea;
        s_valid = v;
        s_data  = byte_at(idx);
        start   = st;
        abort   = ab;
        xf      = v && s_ready;
        exp_we  = xf && !ab && (idx < TBL);
        ea      = idx;
        if (xf && !ab) idx++;
        @(negedge clk);
        if (bram_we !== exp_we) wr_err++;
        else if (exp_we && (bram_addr !== ea[ABITS-1:0] || bram_din !== ea[7:0])) wr_err++;
        if (bram_we) writes++;
        if (done) dones++;
    endtask

    task automatic clr_counts();
        idx = 0; writes = 0; wr_err = 0; dones = 0;
    endtask

    task automatic feed_to(input int stop_idx);
        int n = 0;
        while (idx < stop_idx && n < 20000) begin
            cyc(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("feed_budget", (n < 20000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        vecs[0] = '{lo: 8'h00, hi: 8'hF8, gap_pct: 0,  exp_tv: 1'b1, exp_err: 1'b0};
        vecs[1] = '{lo: 8'h00, hi: 8'hF8, gap_pct: 50, exp_tv: 1'b1, exp_err: 1'b0};
        vecs[2] = '{lo: 8'h01, hi: 8'hF8, gap_pct: 0,  exp_tv: 1'b0, exp_err: 1'b1};
        vecs[3] = '{lo: 8'h00, hi: 8'hF8, gap_pct: 0,  exp_tv: 1'b1, exp_err: 1'b0};

        rstn = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        cur_lo = 8'h00; cur_hi = 8'hF8;
        @(negedge clk); @(negedge clk);
        chk("rst_outs", {s_ready, bram_we, busy, done, table_valid, csum_err}, 32'd0);
        chk("rst_addr_din", {bram_addr, bram_din}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Full loads from the vector table, each started from IDLE/FINISH.
        for (int v = 0; v < 4; v++) begin
            int n;
            clr_counts();
            cur_lo = vecs[v].lo;
            cur_hi = vecs[v].hi;
            cyc(1'b0, 1'b1, 1'b0);
            chk($sformatf("v%0d_tv_after_start", v), table_valid, 1'b0);
            chk($sformatf("v%0d_busy", v), busy, 1'b1);
            n = 0;
            while (idx < TBL + 2 && n < 20000) begin
                cyc(($urandom_range(99) >= vecs[v].gap_pct) ? 1'b1 : 1'b0, 1'b0, 1'b0);
                n++;
            end
            while (dones == 0 && n < 20000) begin
                cyc(1'b0, 1'b0, 1'b0);
                n++;
            end
            chk($sformatf("v%0d_done_seen", v), dones, 32'd1);
            chk($sformatf("v%0d_table_valid", v), table_valid, vecs[v].exp_tv);
            chk($sformatf("v%0d_csum_err", v), csum_err, vecs[v].exp_err);
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d_done_once", v), dones, 32'd1);
            chk($sformatf("v%0d_writes", v), writes, TBL);
            chk($sformatf("v%0d_wr_err", v), wr_err, 32'd0);
            chk($sformatf("v%0d_idle_flags", v), {busy, s_ready}, 32'd0);
        end

        // Start ignored at address 100, then abort with a byte offered at address 200.
        clr_counts();
        cur_lo = 8'h00; cur_hi = 8'hF8;
        cyc(1'b0, 1'b1, 1'b0);
        feed_to(100);
        cyc(1'b1, 1'b1, 1'b0);
        feed_to(200);
        cyc(1'b1, 1'b0, 1'b1);
        chk("abort_ready", s_ready, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_tv", table_valid, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("abort_writes", writes, 32'd200);
        chk("abort_wr_err", wr_err, 32'd0);
        chk("abort_no_done", dones, 32'd0);

        // Abort together with the high checksum byte: CHECK must never be reached.
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0);
        feed_to(TBL + 1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("hi_abort_ready", s_ready, 1'b0);
        chk("hi_abort_busy", busy, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0);
        chk("hi_abort_no_done", dones, 32'd0);
        chk("hi_abort_tv", table_valid, 1'b0);
        chk("hi_abort_writes", writes, TBL);
        chk("hi_abort_wr_err", wr_err, 32'd0);

        // Asynchronous reset mid-load: outputs clear between clock edges.
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0);
        feed_to(100);
        s_valid = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("arst_outs", {s_ready, bram_we, busy, done, table_valid, csum_err}, 32'd0);
        chk("arst_addr_din", {bram_addr, bram_din}, 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("arst_idle", {s_ready, busy, table_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
